// File: rtl/spram_ctrl_pkg.sv
// Shared widths and FSM state encoding for the single-port RAM controller.
// Default geometry is a 64x8 RAM.
package spram_ctrl_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RCAP  = 3'd3,
    RESP  = 3'd4,
    CLEAR = 3'd5
  } state_t;

endpackage

// File: rtl/spram_ctrl_if.sv
// RAM-side bus between the controller and a single-port RAM.
// Ports: ce/we/addr/wdata from master (controller), rdata from slave (RAM).
interface spram_ctrl_if
  import spram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              ce;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output ce, we, addr, wdata,
    input  rdata
  );

  modport slave (
    input  ce, we, addr, wdata,
    output rdata
  );

endinterface

// File: rtl/spram_ctrl.sv
// Controller for an external single-port RAM: single read/write requests
// with a valid/ready request port, a held read response, and a clear sweep
// that fills every word with a latched value.
// Ports: i_clk/i_reset (sync, active high); i_req_* request, o_req_ready;
// o_rsp_valid/o_rsp_data with i_rsp_ready; i_clr_start/i_clr_value,
// o_clr_done pulse; o_busy; o_ram_* / i_ram_rdata to the RAM.
module spram_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  input  logic              i_clr_start,
  input  logic [DATA_W-1:0] i_clr_value,
  output logic              o_busy,
  output logic              o_clr_done,
  output logic              o_ram_ce,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH);

  state_t state, state_nx;

  // One extra bit so the terminal count is DEPTH, not a wrap to 0.
  logic [ADDR_W:0] clr_cnt, clr_cnt_nx;
  logic            clr_last;

  logic              ce_nx;
  logic              we_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx;
  logic              rsp_valid_nx;
  logic [DATA_W-1:0] rsp_data_nx;
  logic              done_nx;

  assign clr_last    = (clr_cnt == LAST);
  assign o_busy      = (state != IDLE);
  assign o_req_ready = (state == IDLE) && !i_clr_start;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      o_ram_ce    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_clr_done  <= 1'b0;
    end else begin
      state       <= state_nx;
      clr_cnt     <= clr_cnt_nx;
      o_ram_ce    <= ce_nx;
      o_ram_we    <= we_nx;
      o_ram_addr  <= addr_nx;
      o_ram_wdata <= wdata_nx;
      o_rsp_valid <= rsp_valid_nx;
      o_rsp_data  <= rsp_data_nx;
      o_clr_done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_clr_start)
          state_nx = CLEAR;
        else if (i_req_valid)
          state_nx = i_req_we ? WRITE : READ;
      end
      WRITE: state_nx = IDLE;
      READ:  state_nx = RCAP;
      RCAP:  state_nx = RESP;
      RESP:  if (i_rsp_ready) state_nx = IDLE;
      CLEAR: if (clr_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ce_nx        = 1'b0;
    we_nx        = 1'b0;
    addr_nx      = o_ram_addr;
    wdata_nx     = o_ram_wdata;
    rsp_valid_nx = o_rsp_valid;
    rsp_data_nx  = o_rsp_data;
    done_nx      = 1'b0;
    clr_cnt_nx   = clr_cnt;
    unique case (state)
      IDLE: begin
        if (i_clr_start) begin
          // wdata doubles as the latched fill value for the sweep
          ce_nx      = 1'b1;
          we_nx      = 1'b1;
          addr_nx    = '0;
          wdata_nx   = i_clr_value;
          clr_cnt_nx = (ADDR_W+1)'(1);
        end else if (i_req_valid) begin
          ce_nx   = 1'b1;
          we_nx   = i_req_we;
          addr_nx = i_req_addr;
          if (i_req_we)
            wdata_nx = i_req_data;
        end
      end
      RCAP: begin
        rsp_valid_nx = 1'b1;
        rsp_data_nx  = i_ram_rdata;
      end
      RESP: begin
        if (i_rsp_ready)
          rsp_valid_nx = 1'b0;
      end
      CLEAR: begin
        if (clr_last) begin
          done_nx    = 1'b1;
          clr_cnt_nx = '0;
        end else begin
          ce_nx      = 1'b1;
          we_nx      = 1'b1;
          addr_nx    = clr_cnt[ADDR_W-1:0];
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
